// File: rtl/rc5_pkg.sv
// Shared types and rotate helpers for the RC5 block core.
// Rotates work on the low w bits of a 32-bit container.
package rc5_pkg;

    localparam int W_DEF = 8;
    localparam int R_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RND_A,
        RND_B,
        FIN,
        OUT
    } state_t;

    function automatic logic [31:0] wmask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] rotl_w(
        input logic [31:0] x,
        input logic [4:0]  amt,
        input int          w
    );
        logic [31:0] m;
        logic [31:0] v;
        m = wmask(w);
        v = x & m;
        if (amt == 5'd0) return v;
        return ((v << amt) | (v >> (w - int'(amt)))) & m;
    endfunction

    function automatic logic [31:0] rotr_w(
        input logic [31:0] x,
        input logic [4:0]  amt,
        input int          w
    );
        logic [31:0] m;
        logic [31:0] v;
        m = wmask(w);
        v = x & m;
        if (amt == 5'd0) return v;
        return ((v >> amt) | (v << (w - int'(amt)))) & m;
    endfunction

endpackage

// File: rtl/rc5_if.sv
// Key-load port plus in/out valid-ready handshakes of the RC5 core.
interface rc5_if #(
    parameter int W  = 8,
    parameter int AW = 3
);
    logic            key_wr;
    logic [AW-1:0]   key_addr;
    logic [W-1:0]    key_data;
    logic            in_valid;
    logic            in_ready;
    logic            mode;
    logic [2*W-1:0]  din;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  dout;

    modport master (
        output key_wr, key_addr, key_data,
        output in_valid, mode, din, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  key_wr, key_addr, key_data,
        input  in_valid, mode, din, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/rc5_key_regfile.sv
// NK x W subkey store: writable only while idle, two async read ports.
module rc5_key_regfile #(
    parameter int W  = 8,
    parameter int NK = 6,
    parameter int AW = $clog2(NK)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          idle,
    input  logic          wr,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_e,
    input  logic [AW-1:0] raddr_o,
    output logic [W-1:0]  rdata_e,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] s [NK];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NK; k++) s[k] <= '0;
        end else if (idle && wr && (int'(waddr) < NK)) begin
            s[waddr] <= wdata;
        end
    end

    assign rdata_e = s[raddr_e];
    assign rdata_o = s[raddr_o];
endmodule

// File: rtl/rc5_core_param.sv
// Iterative RC5 encrypt/decrypt core, one half-round per clock.
module rc5_core_param
    import rc5_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int R = R_DEF
) (
    input logic  clock,
    input logic  reset,
    rc5_if.slave bus
);
    localparam int NK = 2 * R + 2;
    localparam int AW = $clog2(NK);
    localparam int CW = $clog2(R + 1);
    localparam int SW = $clog2(W);

    state_t          state;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [CW-1:0]   i;
    logic            dec;
    logic            rdy;
    logic            vld;
    logic [2*W-1:0]  res;

    logic [CW-1:0]   ri;
    logic [AW-1:0]   ae;
    logic [AW-1:0]   ao;
    logic [W-1:0]    se;
    logic [W-1:0]    so;
    logic [W-1:0]    enc_a;
    logic [W-1:0]    enc_b;
    logic [W-1:0]    dec_a;
    logic [W-1:0]    dec_b;

    // INIT and FIN always touch S[0]/S[1]; rounds use S[2i]/S[2i+1]
    assign ri = (state == INIT || state == FIN) ? '0 : i;
    assign ae = AW'({ri, 1'b0});
    assign ao = AW'({ri, 1'b1});

    rc5_key_regfile #(.W(W), .NK(NK), .AW(AW)) u_keys (
        .clock   (clock),
        .reset   (reset),
        .idle    (state == IDLE),
        .wr      (bus.key_wr),
        .waddr   (bus.key_addr),
        .wdata   (bus.key_data),
        .raddr_e (ae),
        .raddr_o (ao),
        .rdata_e (se),
        .rdata_o (so)
    );

    assign enc_a = W'(rotl_w(32'(a ^ b), 5'(b[SW-1:0]), W)) + se;
    assign enc_b = W'(rotl_w(32'(b ^ a), 5'(a[SW-1:0]), W)) + so;
    assign dec_a = W'(rotr_w(32'(a - se), 5'(b[SW-1:0]), W)) ^ b;
    assign dec_b = W'(rotr_w(32'(b - so), 5'(a[SW-1:0]), W)) ^ a;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            i     <= '0;
            dec   <= 1'b0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
            res   <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    a     <= bus.din[2*W-1:W];
                    b     <= bus.din[W-1:0];
                    dec   <= bus.mode;
                    i     <= bus.mode ? CW'(R) : CW'(1);
                    rdy   <= 1'b0;
                    state <= INIT;
                end
                INIT: if (dec) begin
                    state <= RND_B;
                end else begin
                    a     <= a + se;
                    b     <= b + so;
                    state <= RND_A;
                end
                RND_A: if (!dec) begin
                    a     <= enc_a;
                    state <= RND_B;
                end else begin
                    a <= dec_a;
                    if (i == CW'(1)) begin
                        state <= FIN;
                    end else begin
                        i     <= i - CW'(1);
                        state <= RND_B;
                    end
                end
                RND_B: if (dec) begin
                    b     <= dec_b;
                    state <= RND_A;
                end else begin
                    b <= enc_b;
                    if (i == CW'(R)) begin
                        vld   <= 1'b1;
                        res   <= {a, enc_b};
                        state <= OUT;
                    end else begin
                        i     <= i + CW'(1);
                        state <= RND_A;
                    end
                end
                FIN: begin
                    a     <= a - se;
                    b     <= b - so;
                    vld   <= 1'b1;
                    res   <= {a - se, b - so};
                    state <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    vld   <= 1'b0;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.dout      = res;
endmodule

// File: doc/rc5_core_param.md
RC5_CORE_PARAM -- requirements
Module: rc5_core_param

Interface
REQ-001 SHALL provide parameter W, default 8: word width in bits; the block is 2W bits; legal values are 8, 16 and 32.
REQ-002 SHALL provide parameter R, default 2: round count; legal values are 1 to 12; the subkey count is NK = 2R+2.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 key_wr  input  1  subkey write strobe.
REQ-006 key_addr  input  $clog2(NK)  subkey index.
REQ-007 key_data  input  W  subkey value.
REQ-008 in_valid  input  1  block offered.
REQ-009 in_ready  output  1  block accepted when in_valid && in_ready.
REQ-010 mode  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
REQ-011 din  input  2W  input block; A = din[2W-1:W], B = din[W-1:0].
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 dout  output  2W  result block, packed as {A,B}.

Function
REQ-015 SHALL implement an FSM with states IDLE, INIT, RND_A, RND_B, FIN, OUT.
REQ-016 SHALL drive in_ready = 1 only in IDLE.
REQ-017 On accept: latch din and mode, set round counter (enc: 1; dec: R), go to INIT.
REQ-018 INIT (enc): A += S[0]; B += S[1]; go to RND_A.
REQ-019 INIT (dec): no arithmetic; go to RND_B.
REQ-020 RND_A (enc): A = rotl(A^B, B mod W) + S[2i]; go to RND_B.
REQ-021 RND_B (enc): B = rotl(B^A, A mod W) + S[2i+1]; if i == R go to OUT, else i++ and go to RND_A.
REQ-022 RND_B (dec): B = rotr(B - S[2i+1], A mod W) ^ A; go to RND_A.
REQ-023 RND_A (dec): A = rotr(A - S[2i], B mod W) ^ B; if i == 1 go to FIN, else i-- and go to RND_B.
REQ-024 FIN (dec only): B -= S[1]; A -= S[0]; go to OUT.
REQ-025 Arithmetic SHALL be modulo 2^W; the rotate amount is the low log2(W) bits of the operand; an amount of 0 SHALL return the operand unchanged.
REQ-026 Latency from accept to out_valid SHALL be 2R+1 cycles for encrypt and 2R+2 cycles for decrypt.
REQ-027 OUT: out_valid = 1 and dout = {A,B}, both held stable until out_ready; on consume go to IDLE.
REQ-028 out_ready while out_valid = 0 SHALL be ignored; in_valid outside IDLE SHALL be ignored, with no buffering.
REQ-029 key_wr SHALL update S[key_addr] only in IDLE; writes in other states, or with key_addr >= NK, SHALL be discarded.
REQ-030 key_wr and accept in the same IDLE cycle: the new subkey SHALL be used by that block.
REQ-031 Changing mode or din after accept SHALL have no effect on the block in flight.

Reset
REQ-032 reset low, asynchronously: state = IDLE, out_valid = 0, dout = 0, A = B = 0, round counter = 0, all S[k] = 0.
REQ-033 After reset: in_ready = 1 in the first cycle following reset release.
REQ-034 reset mid-operation SHALL abort the block with no out_valid pulse; subkeys SHALL be cleared and must be reloaded.

Structure
REQ-035 Package rc5_pkg SHALL hold: the state_t enum, W/R default constants, and pure functions rotl_w/rotr_w parameterised by amount.
REQ-036 Sub-module rc5_key_regfile SHALL implement the NK x W register file: async clear, write port gated by an idle flag, two combinational read ports (even and odd subkey).
REQ-037 No internal subkey generator; the key schedule is loaded externally.

Verification (W=8, R=2 unless stated)
REQ-038 All S = 00, din = 0000, encrypt -> dout = 16'h0000 after 5 cycles.
REQ-039 S[0..5] = 01,02,03,04,05,06, din = 0000, encrypt -> dout = 16'h1B92; intermediates A/B = 01/02, 0F/8A, 1B/92.
REQ-040 Same keys, din = 1B92, decrypt -> dout = 16'h0000 after 6 cycles.
REQ-041 out_ready held low 10 cycles -> out_valid and dout stable, in_ready = 0 throughout; key_wr during this window leaves S unchanged.
REQ-042 reset asserted in RND_B -> out_valid never asserts, S reads 00, next encrypt of 0000 gives 0000.
REQ-043 W=16, R=12, random keys and blocks -> encrypt-then-decrypt round-trip equals input for 1000 blocks, with back-to-back handshakes.
